spi_buffered_slave: RTL and testbench

Next-generation SPI slave with receive and transmit buffering. It oversamples the external SPI bus in the system clock domain and supports all four CPOL/CPHA modes. Completed words are pushed into an RX FIFO, and words to transmit are popped from a TX FIFO. Both FIFOs are exposed through valid/ready handshakes to the host-side logic.

---
 rtl/spi_pkg.sv | 26 ++
 rtl/spi_sync_fifo.sv | 71 +++++++
 rtl/spi_buffered_slave.sv | 238 +++++++++++++++++++++++
 tb/tb_spi_buffered_slave.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the buffered SPI slave.
//   spi_mode_t  : the four CPOL/CPHA combinations (MODE0..MODE3 = {CPOL,CPHA})
//   spi_state_t : frame state of the shift engine
//   SYNC_STAGES : depth of the input synchronisers
//   spi_mode()  : builds a spi_mode_t from integer CPOL/CPHA parameters
package spi_pkg;

  typedef enum logic [1:0] {
    MODE0 = 2'd0,
    MODE1 = 2'd1,
    MODE2 = 2'd2,
    MODE3 = 2'd3
  } spi_mode_t;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } spi_state_t;

  localparam int SYNC_STAGES = 2;

  function automatic spi_mode_t spi_mode(input int cpol, input int cpha);
    return spi_mode_t'({cpol[0], cpha[0]});
  endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock first-word-fall-through FIFO used for both the RX and TX queues.
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   push, push_data    write request and word
//   pop                read request (ignored while empty)
//   pop_data           head word, 0 while empty
//   count              occupancy 0..FIFO_DEPTH
//   full, empty        derived from count
// A push while full is accepted only when a pop happens in the same cycle,
// so the count stays at FIFO_DEPTH.
module spi_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  push,
  input  logic [DATA_WIDTH-1:0]                 push_data,
  input  logic                                  pop,
  output logic [DATA_WIDTH-1:0]                 pop_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]       count,
  output logic                                  full,
  output logic                                  empty
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic                  do_push;
  logic                  do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign count    = count_q;
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Storage array; no reset needed because empty masks the head word.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/spi_buffered_slave.sv
// SPI slave with RX and TX FIFOs, oversampling the SPI bus in the clk domain.
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   cs_n, sck, mosi       asynchronous SPI bus inputs
//   miso                  serial output, 0 while not selected
//   rx_data/valid/ready   RX FIFO head (first-word fall-through) and pop handshake
//   tx_data/valid/ready   TX FIFO push handshake
//   rx_count, tx_count    FIFO occupancies
//   rx_overflow           sticky: received word dropped on full RX FIFO
//   tx_underflow          sticky: TX_IDLE sent because the TX FIFO was empty
//   clear_flags           clears both sticky flags (a same-cycle set wins)
module spi_buffered_slave
  import spi_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    FIFO_DEPTH = 16,
  parameter int                    CPOL       = 0,
  parameter int                    CPHA       = 0,
  parameter logic [DATA_WIDTH-1:0] TX_IDLE    = '0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cs_n,
  input  logic                            sck,
  input  logic                            mosi,
  output logic                            miso,
  output logic [DATA_WIDTH-1:0]           rx_data,
  output logic                            rx_valid,
  input  logic                            rx_ready,
  input  logic [DATA_WIDTH-1:0]           tx_data,
  input  logic                            tx_valid,
  output logic                            tx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] rx_count,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] tx_count,
  output logic                            rx_overflow,
  output logic                            tx_underflow,
  input  logic                            clear_flags
);

  localparam spi_mode_t MODE            = spi_mode(CPOL, CPHA);
  localparam logic      SCK_IDLE        = (MODE == MODE2) || (MODE == MODE3);
  localparam logic      SAMPLE_ON_TRAIL = (MODE == MODE1) || (MODE == MODE3);
  localparam int        BW              = $clog2(DATA_WIDTH);

  logic [SYNC_STAGES:0]   cs_sync;
  logic [SYNC_STAGES:0]   sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;

  logic cs_s, cs_prev, sck_s, sck_prev, mosi_s;
  logic cs_fall, cs_rise, lead_edge, trail_edge, sample_edge, shift_edge;

  spi_state_t            state;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] rx_word;
  logic                  rx_push;
  logic                  miso_q;
  logic                  need_load;
  logic                  need_present;
  logic                  udf_pending;

  logic                  frame_load, mid_load, tx_pop;
  logic [DATA_WIDTH-1:0] tx_head, load_word;
  logic                  tx_full, tx_empty, rx_full, rx_empty;
  logic                  rx_pop_fire, rx_drop, udf_set, last_bit, in_frame;

  // cs_n resets to 0 so that a frame cut by reset is not mistaken for a
  // new one: only a genuine high-to-low transition of cs_n starts a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sync   <= '0;
      sck_sync  <= {(SYNC_STAGES+1){SCK_IDLE}};
      mosi_sync <= '0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-1:0], cs_n};
      sck_sync  <= {sck_sync[SYNC_STAGES-1:0], sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    end
  end

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign cs_prev  = cs_sync[SYNC_STAGES];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign sck_prev = sck_sync[SYNC_STAGES];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];

  assign cs_fall     = !cs_s && cs_prev;
  assign cs_rise     = cs_s && !cs_prev;
  assign lead_edge   = (sck_s != SCK_IDLE) && (sck_prev == SCK_IDLE);
  assign trail_edge  = (sck_s == SCK_IDLE) && (sck_prev != SCK_IDLE);
  assign sample_edge = SAMPLE_ON_TRAIL ? trail_edge : lead_edge;
  assign shift_edge  = SAMPLE_ON_TRAIL ? lead_edge : trail_edge;

  assign in_frame    = (state == ST_ACTIVE) && !cs_rise;
  assign frame_load  = (state == ST_IDLE) && cs_fall;
  assign mid_load    = in_frame && shift_edge && need_load;
  assign tx_pop      = (frame_load || mid_load) && !tx_empty;
  assign load_word   = tx_empty ? TX_IDLE : tx_head;
  assign last_bit    = (bit_cnt == BW'(DATA_WIDTH - 1));

  assign rx_pop_fire = rx_ready && !rx_empty;
  assign rx_drop     = rx_push && rx_full && !rx_pop_fire;
  // A word loaded mid-frame only counts as an underflow once the master
  // actually samples its first bit; the extra load after the final word of
  // a CPHA=0 frame is usually discarded by cs_n rising.
  assign udf_set     = (frame_load && tx_empty) ||
                       (in_frame && sample_edge && udf_pending);

  assign miso     = miso_q;
  assign rx_valid = !rx_empty;
  assign tx_ready = !tx_full;

  // Frame state machine and shift engine. need_load marks a word boundary
  // where the next shift edge must load instead of shift; need_present
  // (CPHA=1) defers the first MSB to the first leading edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      rx_shift     <= '0;
      tx_shift     <= '0;
      rx_word      <= '0;
      rx_push      <= 1'b0;
      miso_q       <= 1'b0;
      need_load    <= 1'b0;
      need_present <= 1'b0;
      udf_pending  <= 1'b0;
    end else begin
      rx_push <= 1'b0;
      case (state)
        ST_IDLE: begin
          miso_q <= 1'b0;
          if (cs_fall) begin
            state        <= ST_ACTIVE;
            bit_cnt      <= '0;
            rx_shift     <= '0;
            tx_shift     <= load_word;
            miso_q       <= SAMPLE_ON_TRAIL ? 1'b0 : load_word[DATA_WIDTH-1];
            need_load    <= 1'b0;
            need_present <= SAMPLE_ON_TRAIL;
            udf_pending  <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (cs_rise) begin
            state        <= ST_IDLE;
            miso_q       <= 1'b0;
            bit_cnt      <= '0;
            rx_shift     <= '0;
            need_load    <= 1'b0;
            need_present <= 1'b0;
            udf_pending  <= 1'b0;
          end else begin
            if (shift_edge) begin
              if (need_load) begin
                tx_shift    <= load_word;
                miso_q      <= load_word[DATA_WIDTH-1];
                need_load   <= 1'b0;
                udf_pending <= tx_empty;
              end else if (need_present) begin
                miso_q       <= tx_shift[DATA_WIDTH-1];
                need_present <= 1'b0;
              end else begin
                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                miso_q   <= tx_shift[DATA_WIDTH-2];
              end
            end
            if (sample_edge) begin
              rx_shift    <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
              udf_pending <= 1'b0;
              if (last_bit) begin
                bit_cnt   <= '0;
                rx_word   <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
                rx_push   <= 1'b1;
                need_load <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky flags: the set term is applied after the clear so a same-cycle
  // set wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_overflow  <= 1'b0;
      tx_underflow <= 1'b0;
    end else begin
      if (clear_flags) begin
        rx_overflow  <= 1'b0;
        tx_underflow <= 1'b0;
      end
      if (rx_drop) begin
        rx_overflow <= 1'b1;
      end
      if (udf_set) begin
        tx_underflow <= 1'b1;
      end
    end
  end

  spi_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push),
    .push_data (rx_word),
    .pop       (rx_ready),
    .pop_data  (rx_data),
    .count     (rx_count),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  spi_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_valid),
    .push_data (tx_data),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .count     (tx_count),
    .full      (tx_full),
    .empty     (tx_empty)
  );

endmodule

// File: tb/tb_spi_buffered_slave.sv
// Testbench for spi_buffered_slave: one instance per SPI mode (index = mode),
// all with 8-bit words, 4-entry FIFOs and TX_IDLE = 0xFF. A bit-level SPI
// master drives the selected instance; expected words go into scoreboard
// queues when a frame is driven and are popped when the master or the RX
// FIFO produces the corresponding word.
module tb_spi_buffered_slave;

  logic       clk;
  logic       reset;
  logic       mosi;
  logic       cs_n        [4];
  logic       sck         [4];
  logic       rx_ready    [4];
  logic       tx_valid    [4];
  logic       clear_flags [4];
  logic [7:0] tx_data     [4];
  logic       miso        [4];
  logic [7:0] rx_data     [4];
  logic       rx_valid    [4];
  logic       tx_ready    [4];
  logic [2:0] rx_count    [4];
  logic [2:0] tx_count    [4];
  logic       rx_overflow [4];
  logic       tx_underflow[4];

  int          tests_run;
  int          tests_failed;
  logic [7:0]  rx_exp[$];
  logic [7:0]  miso_exp[$];
  logic [63:0] got;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_buffered_slave #(
      .DATA_WIDTH (8),
      .FIFO_DEPTH (4),
      .CPOL       (g / 2),
      .CPHA       (g % 2),
      .TX_IDLE    (8'hFF)
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .cs_n         (cs_n[g]),
      .sck          (sck[g]),
      .mosi         (mosi),
      .miso         (miso[g]),
      .rx_data      (rx_data[g]),
      .rx_valid     (rx_valid[g]),
      .rx_ready     (rx_ready[g]),
      .tx_data      (tx_data[g]),
      .tx_valid     (tx_valid[g]),
      .tx_ready     (tx_ready[g]),
      .rx_count     (rx_count[g]),
      .tx_count     (tx_count[g]),
      .rx_overflow  (rx_overflow[g]),
      .tx_underflow (tx_underflow[g]),
      .clear_flags  (clear_flags[g])
    );
  end

  // 10-unit system clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation still running, required finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Half an SCK period = 8 clk cycles, so f_sck = f_clk/16
  task automatic halfWait();
    repeat (8) @(negedge clk);
  endtask

  // SPI master: one cs_n frame of nbits, MSB of the stream first
  task automatic applyStimulus(input int m, input int nbits,
                               input logic [63:0] bits_out,
                               output logic [63:0] bits_in);
    logic cpol, cpha;
    cpol    = ((m >> 1) & 1) != 0;
    cpha    = (m & 1) != 0;
    bits_in = '0;
    @(negedge clk);
    cs_n[m] = 1'b0;
    if (!cpha) mosi = bits_out[nbits-1];
    halfWait();
    for (int i = nbits - 1; i >= 0; i--) begin
      if (!cpha) begin
        bits_in = {bits_in[62:0], miso[m]};
        sck[m]  = !cpol;
        halfWait();
        sck[m] = cpol;
        if (i > 0) mosi = bits_out[i-1];
        halfWait();
      end else begin
        sck[m] = !cpol;
        mosi   = bits_out[i];
        halfWait();
        bits_in = {bits_in[62:0], miso[m]};
        sck[m]  = cpol;
        halfWait();
      end
    end
    cs_n[m] = 1'b1;
    halfWait();
    halfWait();
  endtask

  task automatic pushTx(input int m, input logic [7:0] word);
    @(negedge clk);
    tx_data[m]  = word;
    tx_valid[m] = 1'b1;
    @(negedge clk);
    tx_valid[m] = 1'b0;
  endtask

  task automatic clearFlags(input int m);
    @(negedge clk);
    clear_flags[m] = 1'b1;
    @(negedge clk);
    clear_flags[m] = 1'b0;
  endtask

  // Compare words the master received against the miso scoreboard
  task automatic checkMaster(input int m, input int nwords, input logic [63:0] bits);
    logic [7:0] obs, exp;
    for (int i = 0; i < nwords; i++) begin
      obs = bits[8*(nwords-1-i) +: 8];
      if (miso_exp.size() > 0) exp = miso_exp.pop_front();
      else exp = 8'hxx;
      checkOutput($sformatf("m%0d_master_word%0d", m, i), {24'd0, obs}, {24'd0, exp});
    end
  endtask

  // Pop the RX FIFO once per expected word, comparing the head each time
  task automatic drainRx(input int m);
    logic [7:0] exp;
    int waited;
    while (rx_exp.size() > 0) begin
      exp    = rx_exp.pop_front();
      waited = 0;
      while (!rx_valid[m] && waited < 64) begin
        @(negedge clk);
        waited++;
      end
      checkOutput($sformatf("m%0d_rx_valid_wait", m), {31'd0, rx_valid[m]}, 32'd1);
      checkOutput($sformatf("m%0d_rx_data", m), {24'd0, rx_data[m]}, {24'd0, exp});
      rx_ready[m] = 1'b1;
      @(negedge clk);
      rx_ready[m] = 1'b0;
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    mosi         = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cs_n[i]        = 1'b1;
      sck[i]         = (i >= 2);
      rx_ready[i]    = 1'b0;
      tx_valid[i]    = 1'b0;
      tx_data[i]     = 8'h00;
      clear_flags[i] = 1'b0;
    end
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Reset state of every instance
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rst%0d_rx_valid", i), {31'd0, rx_valid[i]}, 32'd0);
      checkOutput($sformatf("rst%0d_tx_ready", i), {31'd0, tx_ready[i]}, 32'd1);
      checkOutput($sformatf("rst%0d_rx_count", i), {29'd0, rx_count[i]}, 32'd0);
      checkOutput($sformatf("rst%0d_tx_count", i), {29'd0, tx_count[i]}, 32'd0);
      checkOutput($sformatf("rst%0d_rx_data", i), {24'd0, rx_data[i]}, 32'd0);
      checkOutput($sformatf("rst%0d_miso", i), {31'd0, miso[i]}, 32'd0);
      checkOutput($sformatf("rst%0d_flags", i), {30'd0, rx_overflow[i], tx_underflow[i]}, 32'd0);
    end

    // Mode 0: preload 0xA5, master sends 0x3C
    pushTx(0, 8'hA5);
    checkOutput("m0_tx_count_pre", {29'd0, tx_count[0]}, 32'd1);
    miso_exp.push_back(8'hA5);
    rx_exp.push_back(8'h3C);
    applyStimulus(0, 8, 64'h3C, got);
    checkOutput("m0_rx_valid", {31'd0, rx_valid[0]}, 32'd1);
    checkOutput("m0_rx_count", {29'd0, rx_count[0]}, 32'd1);
    checkOutput("m0_tx_count_post", {29'd0, tx_count[0]}, 32'd0);
    checkOutput("m0_tx_underflow", {31'd0, tx_underflow[0]}, 32'd0);
    checkOutput("m0_miso_idle", {31'd0, miso[0]}, 32'd0);
    checkMaster(0, 1, got);
    drainRx(0);
    checkOutput("m0_rx_valid_drained", {31'd0, rx_valid[0]}, 32'd0);

    // Modes 1..3: 0x81 from master, 0x7E from slave
    for (int m = 1; m < 4; m++) begin
      pushTx(m, 8'h7E);
      miso_exp.push_back(8'h7E);
      rx_exp.push_back(8'h81);
      applyStimulus(m, 8, 64'h81, got);
      checkOutput($sformatf("m%0d_rx_count", m), {29'd0, rx_count[m]}, 32'd1);
      checkMaster(m, 1, got);
      drainRx(m);
      checkOutput($sformatf("m%0d_flags", m), {30'd0, rx_overflow[m], tx_underflow[m]}, 32'd0);
    end

    // Overflow: five words into a 4-entry RX FIFO with TX empty
    for (int i = 0; i < 5; i++) miso_exp.push_back(8'hFF);
    rx_exp.push_back(8'h11);
    rx_exp.push_back(8'h22);
    rx_exp.push_back(8'h33);
    rx_exp.push_back(8'h44);
    applyStimulus(0, 40, 64'h11_22_33_44_55, got);
    checkOutput("ovf_rx_count", {29'd0, rx_count[0]}, 32'd4);
    checkOutput("ovf_rx_overflow", {31'd0, rx_overflow[0]}, 32'd1);
    checkOutput("ovf_tx_underflow", {31'd0, tx_underflow[0]}, 32'd1);
    checkMaster(0, 5, got);
    drainRx(0);
    checkOutput("ovf_rx_count_drained", {29'd0, rx_count[0]}, 32'd0);
    clearFlags(0);
    checkOutput("ovf_flags_cleared", {30'd0, rx_overflow[0], tx_underflow[0]}, 32'd0);

    // TX empty at frame start, push during word 0 feeds word 1
    for (int m = 0; m < 2; m++) begin
      checkOutput($sformatf("udf%0d_pre", m), {31'd0, tx_underflow[m]}, 32'd0);
      miso_exp.push_back(8'hFF);
      miso_exp.push_back(8'h5A);
      rx_exp.push_back(8'hC3);
      rx_exp.push_back(8'h96);
      fork
        applyStimulus(m, 16, 64'hC396, got);
        begin
          repeat (40) @(negedge clk);
          pushTx(m, 8'h5A);
        end
      join
      checkMaster(m, 2, got);
      drainRx(m);
      checkOutput($sformatf("udf%0d_flag", m), {31'd0, tx_underflow[m]}, 32'd1);
      checkOutput($sformatf("udf%0d_tx_count", m), {29'd0, tx_count[m]}, 32'd0);
    end

    // cs_n raised after 5 bits, then a full 0x55
    applyStimulus(0, 5, 64'h16, got);
    checkOutput("part_rx_count", {29'd0, rx_count[0]}, 32'd0);
    checkOutput("part_miso_idle", {31'd0, miso[0]}, 32'd0);
    miso_exp.push_back(8'hFF);
    rx_exp.push_back(8'h55);
    applyStimulus(0, 8, 64'h55, got);
    checkOutput("part_rx_count_full", {29'd0, rx_count[0]}, 32'd1);
    checkMaster(0, 1, got);
    drainRx(0);
    checkOutput("part_miso_idle2", {31'd0, miso[0]}, 32'd0);

    // Reset mid-byte with both FIFOs at two entries
    applyStimulus(0, 16, 64'h0102, got);
    checkOutput("rstm_rx_count_pre", {29'd0, rx_count[0]}, 32'd2);
    pushTx(0, 8'h10);
    pushTx(0, 8'h20);
    pushTx(0, 8'h30);
    checkOutput("rstm_tx_count_pre", {29'd0, tx_count[0]}, 32'd3);
    fork
      applyStimulus(0, 8, 64'hAA, got);
      begin
        repeat (60) @(negedge clk);
        checkOutput("rstm_tx_count_mid", {29'd0, tx_count[0]}, 32'd2);
        checkOutput("rstm_rx_count_mid", {29'd0, rx_count[0]}, 32'd2);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rstm_rx_count", {29'd0, rx_count[0]}, 32'd0);
        checkOutput("rstm_tx_count", {29'd0, tx_count[0]}, 32'd0);
        checkOutput("rstm_rx_valid", {31'd0, rx_valid[0]}, 32'd0);
        checkOutput("rstm_tx_ready", {31'd0, tx_ready[0]}, 32'd1);
        checkOutput("rstm_flags", {30'd0, rx_overflow[0], tx_underflow[0]}, 32'd0);
        reset = 1'b0;
      end
    join
    checkOutput("rstm_rx_count_after", {29'd0, rx_count[0]}, 32'd0);
    checkOutput("rstm_miso_idle", {31'd0, miso[0]}, 32'd0);
    pushTx(0, 8'h3A);
    miso_exp.push_back(8'h3A);
    rx_exp.push_back(8'hE7);
    applyStimulus(0, 8, 64'hE7, got);
    checkMaster(0, 1, got);
    drainRx(0);
    checkOutput("rstm_flags_after", {30'd0, rx_overflow[0], tx_underflow[0]}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
